// File: rtl/str_case_ctrl.sv
// str_case_ctrl
// Streaming controller for byte-wise ASCII case conversion, one string at a time.
// Input bytes arrive on a valid/ready port. Each byte is optionally upper-cased,
// then pushed into a small output FIFO that drives a valid/ready output port.
// The block counts accepted bytes and converted bytes, and pulses done once the
// whole string has been delivered downstream.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, mode_upper               begin a string (IDLE only), latch conversion mode
//   in_valid/in_ready/in_data/in_last     input byte stream
//   out_valid/out_ready/out_data/out_last output byte stream (FIFO head)
//   busy                            high in RUN and DRAIN
//   done                            one-cycle pulse after the last byte is popped
//   char_count, conv_count          saturating counters for the current/last string
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; counters hold their last values
// RUN   | accepting input bytes until a terminator (in_last or 0x00)
// DRAIN | input closed, waiting for the FIFO to empty
// DONE  | single cycle, done pulse high, then back to IDLE

module str_case_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_upper,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] char_count,
    output logic [CNT_W-1:0] conv_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] char_q, char_d;
    logic [CNT_W-1:0] conv_q, conv_d;
    logic             done_q;

    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;

    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic             is_term;
    logic [7:0]       conv_data;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign in_ready  = (state_q == S_RUN) && !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign is_term   = in_last || (in_data == 8'h00);

    // Lower-case letters lose bit 5 in upper mode; everything else passes through.
    always_comb begin
        conv_data = in_data;
        if (mode_q && (in_data >= 8'h61) && (in_data <= 8'h7A)) begin
            conv_data = in_data & 8'hDF;
        end
    end

    // Head is masked while empty so the output reads 0 after reset/flush
    // without needing to clear the storage array.
    always_comb begin
        {out_last, out_data} = 9'h000;
        if (!fifo_empty) begin
            {out_last, out_data} = mem_q[rd_ptr_q[PTR_W-1:0]];
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        char_d  = char_q;
        conv_d  = conv_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode_upper;
                    char_d  = '0;
                    conv_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    if (char_q != '1) begin
                        char_d = char_q + 1'b1;
                    end
                    if ((conv_data != in_data) && (conv_q != '1)) begin
                        conv_d = conv_q + 1'b1;
                    end
                    if (is_term) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            char_q   <= '0;
            conv_q   <= '0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            char_q  <= char_d;
            conv_q  <= conv_d;
            done_q  <= (state_d == S_DONE);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {is_term, conv_data};
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = done_q;
    assign char_count = char_q;
    assign conv_count = conv_q;

endmodule

// File: tb/tb_str_case_ctrl.sv
module tb_str_case_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode_upper = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] char_count;
    logic [15:0] conv_count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          accepted = 0;
    logic [8:0]  sb_q[$];

    str_case_ctrl #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_upper(mode_upper),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .char_count(char_count), .conv_count(conv_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge when out_valid && out_ready.
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got 0x%0h expected nothing", {out_last, out_data});
            end else begin
                e = sb_q.pop_front();
                check("out_byte", {23'b0, out_last, out_data}, {23'b0, e});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] exp_d, input logic exp_l);
        int t = 0;
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!ok && t < 300) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else t++;
        end
        if (ok) begin
            sb_q.push_back({exp_l, exp_d});
            @(posedge clk);
            #1;
            accepted++;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 (byte 0x%0h)", d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start(input logic m);
        start      = 1'b1;
        mode_upper = m;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_char, input int exp_conv);
        int t = 0;
        bit seen = 0;
        while (!seen && t < 200) begin
            @(negedge clk);
            if (done) seen = 1;
            else t++;
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        if (seen) begin
            check("all_popped_at_done", sb_q.size(), 32'd0);
            check("char_count", {16'b0, char_count}, exp_char);
            check("conv_count", {16'b0, conv_count}, exp_conv);
            check("busy_in_done", {31'b0, busy}, 32'd0);
            @(negedge clk);
            check("done_one_cycle", {31'b0, done}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int t0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_out_data", {23'b0, out_last, out_data}, 32'd0);
        check("rst_counts", {char_count, conv_count}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd0);

        // Basic upper: 0x61 0x5A 0x7B 0x60
        do_start(1'b1);
        check("busy_run", {31'b0, busy}, 32'd1);
        out_ready = 1'b1;
        send(8'h61, 1'b0, 8'h41, 1'b0);
        send(8'h5A, 1'b0, 8'h5A, 1'b0);
        send(8'h7B, 1'b0, 8'h7B, 1'b0);
        send(8'h60, 1'b1, 8'h60, 1'b1);
        wait_done(4, 1);

        // Pass-through with NUL terminator
        do_start(1'b0);
        send(8'h68, 1'b0, 8'h68, 1'b0);
        send(8'h69, 1'b0, 8'h69, 1'b0);
        send(8'h00, 1'b0, 8'h00, 1'b1);
        wait_done(3, 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_char", {16'b0, char_count}, 32'd3);

        // Range boundaries in upper mode
        do_start(1'b1);
        send(8'h7A, 1'b0, 8'h5A, 1'b0);
        send(8'h80, 1'b0, 8'h80, 1'b0);
        send(8'hE1, 1'b0, 8'hE1, 1'b0);
        send(8'h40, 1'b0, 8'h40, 1'b0);
        send(8'h7F, 1'b0, 8'h7F, 1'b0);
        send(8'h61, 1'b1, 8'h41, 1'b1);
        wait_done(6, 2);

        // Backpressure: 4 accepts then stall
        do_start(1'b1);
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(8'h61, 1'b0, 8'h41, 1'b0);
                send(8'h62, 1'b0, 8'h42, 1'b0);
                send(8'h63, 1'b0, 8'h43, 1'b0);
                send(8'h64, 1'b0, 8'h44, 1'b0);
                send(8'h65, 1'b0, 8'h45, 1'b0);
                send(8'h66, 1'b1, 8'h46, 1'b1);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                check("bp_accepted", accepted, 32'd4);
                check("bp_in_ready", {31'b0, in_ready}, 32'd0);
                check("bp_out_valid", {31'b0, out_valid}, 32'd1);
                check("bp_head_held", {23'b0, out_last, out_data}, 32'h041);
                check("bp_no_done", {31'b0, done}, 32'd0);
                out_ready = 1'b1;
            end
        join
        wait_done(6, 6);

        // Full FIFO with simultaneous push and pop
        do_start(1'b0);
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send(8'h30 + 8'(i), (i == 11), 8'h30 + 8'(i), (i == 11));
                end
            end
            begin
                t = 0;
                while (accepted < 4 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                repeat (2) @(posedge clk);
                #1;
                check("full_in_ready", {31'b0, in_ready}, 32'd0);
                out_ready = 1'b1;
                t0 = cycle;
                t = 0;
                while (accepted < 12 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                check("throughput", {31'b0, ((cycle - t0) <= 10)}, 32'd1);
            end
        join
        wait_done(12, 0);

        // start while busy is ignored
        do_start(1'b1);
        send(8'h62, 1'b0, 8'h42, 1'b0);
        do_start(1'b0);
        send(8'h61, 1'b1, 8'h41, 1'b1);
        wait_done(2, 2);

        // Mid-operation asynchronous reset
        do_start(1'b1);
        out_ready = 1'b0;
        send(8'h78, 1'b0, 8'h58, 1'b0);
        send(8'h79, 1'b0, 8'h59, 1'b0);
        send(8'h7A, 1'b0, 8'h5A, 1'b0);
        #2;
        check("pre_rst_char", {16'b0, char_count}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_counts", {char_count, conv_count}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_out_data", {23'b0, out_last, out_data}, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(1'b1);
        out_ready = 1'b1;
        send(8'h71, 1'b1, 8'h51, 1'b1);
        wait_done(1, 1);

        check("sb_empty_end", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/str_case_ctrl.md
Name: str_case_ctrl

Overview:
- Streaming controller that sequences byte-wise ASCII case conversion over one string (message) at a time.
- Accepts bytes over a valid/ready input and passes each through the case-conversion datapath. Buffers converted bytes in a small FIFO and presents them over a valid/ready output.
- Counts total and converted characters, and reports them with a completion pulse.
- Sits between a byte source (UART RX / memory reader) and a byte sink in the text-processing path.

Parameters:
FIFO_DEPTH, 4, output buffer entries; power of 2, >=2
CNT_W, 16, width of character counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begins a string; honoured only in IDLE
mode_upper  input  1  sampled on accepted start: 1 = convert to upper case, 0 = pass-through
in_valid  input  1  input byte valid
in_ready  output  1  controller can accept input byte
in_data  input  8  input byte
in_last  input  1  marks final byte of string
out_valid  output  1  FIFO head valid
out_ready  input  1  sink accepts byte
out_data  output  8  converted byte at FIFO head
out_last  output  1  FIFO head is final byte of string
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when string fully delivered
char_count  output  CNT_W  bytes accepted in current/last string
conv_count  output  CNT_W  bytes whose value changed by conversion

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Conversion function (combinational, inside block):
  - If mode latched 1 and byte in 0x61..0x7A: output = byte with bit 5 cleared.
  - Otherwise: output = byte unchanged. Covers bytes >=0x80, 0x7B..0x7F, 0x60, and mode 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch mode_upper, clear both counters -> RUN. Counters hold their last values while idle.
  - RUN -> DRAIN: on an accepted terminating byte. A byte terminates if in_last=1 or in_data=0x00.
  - DRAIN -> DONE: when FIFO empty.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Input acceptance:
  - Accept = in_valid && in_ready.
  - in_ready = (state==RUN) && !fifo_full. No same-cycle push-while-full bypass.
  - in_ready=0 in all other states.
- FIFO:
  - Entry holds {last, converted byte}. last = in_last || (in_data==0x00).
  - The NUL terminator is forwarded as 0x00 with out_last=1.
- Latency: byte accepted at edge N is visible on out_data/out_valid after edge N (registered FIFO, 1-cycle minimum latency).
- Output handshake:
  - Pop on out_valid && out_ready.
  - out_data/out_last stable while out_valid=1 and out_ready=0.
  - out_valid = !fifo_empty.
- Simultaneous push and pop in one cycle: both happen; occupancy unchanged.
- Counters:
  - char_count += 1 per accepted byte, including the terminator.
  - conv_count += 1 per accepted byte whose converted value differs from the input.
  - Both saturate at 2^CNT_W-1; no wrap.
- start outside IDLE: ignored; no effect on mode or counters.
- Bytes presented while not in RUN: not accepted (in_ready=0). Source must hold them.
- Reset (asynchronous, at any time including mid-string):
  - state=IDLE, FIFO flushed (pointers 0), mode=0.
  - in_ready=0, out_valid=0, out_data=0x00, out_last=0.
  - busy=0, done=0, char_count=0, conv_count=0.
- busy is derived from state (no extra latency). done is registered from the DONE state.

Test Plan:
- Basic upper: start(mode=1), send "aZ{`" with in_last on '`', out_ready=1 -> out "AZ{`"; out_last on 4th byte; done pulse; char_count=4, conv_count=1.
- Pass-through and NUL terminator: start(mode=0), send 0x68,0x69,0x00 -> out 0x68,0x69,0x00 with out_last on 0x00; conv_count=0, char_count=3.
- Backpressure: FIFO_DEPTH=4, out_ready=0, stream 6 bytes -> in_ready drops after 4 accepts. Release out_ready -> all 6 delivered in order; done only after the last pop.
- Simultaneous push and pop at full FIFO: in_valid=1 and out_ready=1 continuously -> sustained 1 byte/cycle after fill; no loss or duplication.
- start while busy: pulse start(mode=0) mid-string in mode 1 -> ignored; remaining 'a' still outputs 'A'.
- Mid-operation reset: assert rst_n=0 with 3 bytes in FIFO -> out_valid=0 and counters 0 immediately (asynchronous). After release, new start(mode=1) "q"+last -> "Q", done, char_count=1.
